divider_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares one `divider` core between two requesters. It grants one requester at a time with round-robin priority and latches that requester's operands. It then drives the core's Start/Ack handshake and returns the quotient and remainder with a one-cycle valid pulse. Divide-by-zero is intercepted so the core is never started with a zero divisor. The block sits between the requesters (switch/button logic or other FSMs) and the `divider` instance, in the `sys_clk` domain of the top level.

---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_share_ctrl_if.sv | 47 ++++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/divider_share_ctrl.sv | 100 ++++++++++
 tb/tb_divider_share_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the divider core and its sharing controller:
// operand width, controller state encoding and the divide-by-zero quotient.
package divider_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] ERR_QUOTIENT = '1;

endpackage

// File: rtl/divider_share_ctrl_if.sv
// Bundle of requester-side and core-side signals around divider_share_ctrl.
// slave is the controller's view; master is the environment's view.
interface divider_share_ctrl_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  // Requester side
  logic             Req0;
  logic             Req1;
  logic [WIDTH-1:0] X0;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] Y1;
  logic [1:0]       Grant;
  logic             Valid0;
  logic             Valid1;
  logic [WIDTH-1:0] Result_Q;
  logic [WIDTH-1:0] Result_R;
  logic             DivErr;
  logic             Busy;

  // Divider core side
  logic [WIDTH-1:0] DivXin;
  logic [WIDTH-1:0] DivYin;
  logic             DivStart;
  logic             DivAck;
  logic             DivDone;
  logic [WIDTH-1:0] DivQuotient;
  logic [WIDTH-1:0] DivRemainder;

  modport slave (
    input  Req0, Req1, X0, Y0, X1, Y1,
    input  DivDone, DivQuotient, DivRemainder,
    output Grant, Valid0, Valid1, Result_Q, Result_R, DivErr, Busy,
    output DivXin, DivYin, DivStart, DivAck
  );

  modport master (
    output Req0, Req1, X0, Y0, X1, Y1,
    output DivDone, DivQuotient, DivRemainder,
    input  Grant, Valid0, Valid1, Result_Q, Result_R, DivErr, Busy,
    input  DivXin, DivYin, DivStart, DivAck
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that was not granted
// last wins. Purely combinational; the caller owns the last_grant register.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] winner
);

  always_comb begin
    // NOTE: winner gets a default before the case so no path leaves it unassigned (no latch).
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_grant ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/divider_share_ctrl.sv
// Shares one divider core between two requesters: arbitrates, latches the
// winner's operands, runs the core's Start/Ack handshake and returns results.
module divider_share_ctrl
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  divider_share_ctrl_if.slave  bus
);

  state_t           state;
  logic             last_grant;
  logic [1:0]       winner;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] y_sel;

  rr_arbiter2 u_arb (
    .req        ({bus.Req1, bus.Req0}),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign x_sel = winner[1] ? bus.X1 : bus.X0;
  assign y_sel = winner[1] ? bus.Y1 : bus.Y0;

  // All outputs are registered; the strobes default low every cycle so each
  // one is a single-cycle pulse unless a branch re-asserts it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state            <= ST_IDLE;
      last_grant       <= 1'b1;
      bus.Grant        <= 2'b00;
      bus.Valid0       <= 1'b0;
      bus.Valid1       <= 1'b0;
      bus.Result_Q     <= '0;
      bus.Result_R     <= '0;
      bus.DivErr       <= 1'b0;
      bus.Busy         <= 1'b0;
      bus.DivXin       <= '0;
      bus.DivYin       <= '0;
      bus.DivStart     <= 1'b0;
      bus.DivAck       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      bus.DivStart <= 1'b0;
      bus.DivAck   <= 1'b0;
      bus.Valid0   <= 1'b0;
      bus.Valid1   <= 1'b0;
      bus.DivErr   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|winner) begin
            bus.Grant  <= winner;
            bus.DivXin <= x_sel;
            bus.DivYin <= y_sel;
            bus.Busy   <= 1'b1;
            last_grant <= winner[1];
            if (y_sel != '0) begin
              bus.DivStart <= 1'b1;
              state        <= ST_START;
            end else begin
              // Zero divisor: answer directly, the core is never started.
              bus.Result_Q <= ERR_QUOTIENT;
              bus.Result_R <= x_sel;
              bus.DivErr   <= 1'b1;
              bus.Valid0   <= winner[0];
              bus.Valid1   <= winner[1];
              state        <= ST_ACK;
            end
          end
        end

        ST_START: state <= ST_WAIT;

        ST_WAIT: begin
          if (bus.DivDone) begin
            bus.Result_Q <= bus.DivQuotient;
            bus.Result_R <= bus.DivRemainder;
            bus.Valid0   <= bus.Grant[0];
            bus.Valid1   <= bus.Grant[1];
            bus.DivAck   <= 1'b1;
            state        <= ST_ACK;
          end
        end

        ST_ACK: begin
          bus.Grant <= 2'b00;
          bus.Busy  <= 1'b0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_share_ctrl.sv
// Directed bench for divider_share_ctrl with a small behavioural divider core.
module tb_divider_share_ctrl;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_share_ctrl_if #(.WIDTH(DIV_WIDTH)) bus ();

  divider_share_ctrl #(.WIDTH(DIV_WIDTH)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural core: loads operands while idle, answers 3 cycles after Start,
  // holds Done until Ack.
  logic [1:0] mst;
  logic [2:0] mcnt;
  logic [3:0] mx, my;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mst <= 2'd0; mcnt <= 3'd0; mx <= 4'd0; my <= 4'd0;
      bus.DivDone <= 1'b0; bus.DivQuotient <= 4'd0; bus.DivRemainder <= 4'd0;
    end else begin
      case (mst)
        2'd0: begin
          mx <= bus.DivXin;
          my <= bus.DivYin;
          if (bus.DivStart) begin mst <= 2'd1; mcnt <= 3'd3; end
        end
        2'd1: begin
          mcnt <= mcnt - 3'd1;
          if (mcnt == 3'd1) begin
            mst <= 2'd2;
            bus.DivDone      <= 1'b1;
            bus.DivQuotient  <= (my == 4'd0) ? 4'hF : mx / my;
            bus.DivRemainder <= (my == 4'd0) ? mx   : mx % my;
          end
        end
        2'd2: if (bus.DivAck) begin mst <= 2'd0; bus.DivDone <= 1'b0; end
        default: mst <= 2'd0;
      endcase
    end
  end

  // Strobe counters and exclusivity monitor.
  int start_cnt = 0;
  int ack_cnt   = 0;
  int viol      = 0;
  always @(negedge clk) begin
    if (bus.DivStart) start_cnt++;
    if (bus.DivAck) ack_cnt++;
    if (bus.Valid0 && bus.Valid1) viol++;
    if ($countones(bus.Grant) > 1) viol++;
  end

  task automatic wait_valid(output logic [1:0] owner, output logic [3:0] q,
                            output logic [3:0] r, output logic err,
                            output logic ack, output logic ok);
    ok = 1'b0; owner = 2'b00; q = 4'd0; r = 4'd0; err = 1'b0; ack = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.Valid0 || bus.Valid1) begin
        owner = {bus.Valid1, bus.Valid0};
        q = bus.Result_Q; r = bus.Result_R;
        err = bus.DivErr; ack = bus.DivAck;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.X0 = 4'd0; bus.Y0 = 4'd0; bus.X1 = 4'd0; bus.Y1 = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.Grant, bus.Valid0, bus.Valid1, bus.DivErr, bus.Busy, bus.DivStart, bus.DivAck} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {bus.Grant, bus.Valid0, bus.Valid1, bus.DivErr, bus.Busy, bus.DivStart, bus.DivAck});
    end
    checks++;
    if ({bus.DivXin, bus.DivYin, bus.Result_Q, bus.Result_R} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0000",
               {bus.DivXin, bus.DivYin, bus.Result_Q, bus.Result_R});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.Grant, bus.Busy} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 000", {bus.Grant, bus.Busy});
    end
  endtask

  task automatic test_single();
    logic [1:0] own; logic [3:0] q, r; logic err, ack, ok;
    int s0, a0;
    s0 = start_cnt; a0 = ack_cnt;
    bus.X0 = 4'd13; bus.Y0 = 4'd4; bus.Req0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.Grant, bus.DivStart, bus.Busy, bus.DivXin, bus.DivYin} !== {2'b01, 1'b1, 1'b1, 4'd13, 4'd4}) begin
      failures++;
      $display("FAIL single_grant: got %h expected %h",
               {bus.Grant, bus.DivStart, bus.Busy, bus.DivXin, bus.DivYin}, {2'b01, 1'b1, 1'b1, 4'd13, 4'd4});
    end
    @(negedge clk);
    checks++;
    if (bus.DivStart !== 1'b0) begin
      failures++;
      $display("FAIL single_start_pulse: got %b expected 0", bus.DivStart);
    end
    wait_valid(own, q, r, err, ack, ok);
    bus.Req0 = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got no Valid expected Valid0"); end
    checks++;
    if ({own, q, r, err, ack} !== {2'b01, 4'd3, 4'd1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_result: got own=%b q=%0d r=%0d err=%b ack=%b expected own=01 q=3 r=1 err=0 ack=1",
               own, q, r, err, ack);
    end
    @(negedge clk);
    checks++;
    if ({bus.Grant, bus.Valid0, bus.DivAck} !== 4'b0000) begin
      failures++;
      $display("FAIL single_release: got %b expected 0000", {bus.Grant, bus.Valid0, bus.DivAck});
    end
    checks++;
    if ((start_cnt - s0 != 1) || (ack_cnt - a0 != 1)) begin
      failures++;
      $display("FAIL single_strobes: got starts=%0d acks=%0d expected 1 and 1", start_cnt - s0, ack_cnt - a0);
    end
  endtask

  task automatic test_tie();
    logic [1:0] own; logic [3:0] q, r; logic err, ack, ok;
    logic [1:0] exp_own [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0] exp_q   [4] = '{4'd4, 4'd3, 4'd4, 4'd3};
    logic [3:0] exp_r   [4] = '{4'd1, 4'd0, 4'd1, 4'd0};
    do_reset();
    bus.X0 = 4'd9; bus.Y0 = 4'd2; bus.X1 = 4'd15; bus.Y1 = 4'd5;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(own, q, r, err, ack, ok);
      checks++;
      if ({ok, own, q, r} !== {1'b1, exp_own[k], exp_q[k], exp_r[k]}) begin
        failures++;
        $display("FAIL tie_service%0d: got ok=%b own=%b q=%0d r=%0d expected ok=1 own=%b q=%0d r=%0d",
                 k, ok, own, q, r, exp_own[k], exp_q[k], exp_r[k]);
      end
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_div_zero();
    int s0, a0;
    s0 = start_cnt; a0 = ack_cnt;
    bus.X1 = 4'd7; bus.Y1 = 4'd0; bus.Req1 = 1'b1;
    @(negedge clk);
    bus.Req1 = 1'b0;
    checks++;
    if ({bus.Grant, bus.Valid0, bus.Valid1, bus.DivErr} !== 5'b10011) begin
      failures++;
      $display("FAIL dz_flags: got %b expected 10011", {bus.Grant, bus.Valid0, bus.Valid1, bus.DivErr});
    end
    checks++;
    if ({bus.Result_Q, bus.Result_R} !== {4'd15, 4'd7}) begin
      failures++;
      $display("FAIL dz_result: got q=%0d r=%0d expected q=15 r=7", bus.Result_Q, bus.Result_R);
    end
    checks++;
    if ({bus.DivStart, bus.DivAck} !== 2'b00) begin
      failures++;
      $display("FAIL dz_strobe_now: got %b expected 00", {bus.DivStart, bus.DivAck});
    end
    repeat (4) @(negedge clk);
    checks++;
    if ((start_cnt != s0) || (ack_cnt != a0) || (bus.Busy !== 1'b0)) begin
      failures++;
      $display("FAIL dz_core_untouched: got starts=%0d acks=%0d busy=%b expected 0 0 0",
               start_cnt - s0, ack_cnt - a0, bus.Busy);
    end
  endtask

  task automatic test_stability();
    logic [1:0] own; logic [3:0] q, r; logic err, ack, ok;
    bus.X0 = 4'd14; bus.Y0 = 4'd3; bus.X1 = 4'd5; bus.Y1 = 4'd1;
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    repeat (2) @(negedge clk);
    bus.Req1 = 1'b0; bus.X0 = 4'd2; bus.Y0 = 4'd1;
    @(negedge clk);
    checks++;
    if ({bus.Grant, bus.DivXin, bus.DivYin, bus.Busy} !== {2'b01, 4'd14, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL stable_operands: got %h expected %h",
               {bus.Grant, bus.DivXin, bus.DivYin, bus.Busy}, {2'b01, 4'd14, 4'd3, 1'b1});
    end
    wait_valid(own, q, r, err, ack, ok);
    bus.Req0 = 1'b0;
    checks++;
    if ({ok, own, q, r, err} !== {1'b1, 2'b01, 4'd4, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL stable_result: got ok=%b own=%b q=%0d r=%0d err=%b expected ok=1 own=01 q=4 r=2 err=0",
               ok, own, q, r, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] own; logic [3:0] q, r; logic err, ack, ok;
    int vseen;
    bus.X0 = 4'd11; bus.Y0 = 4'd2; bus.Req0 = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.Grant, bus.Valid0, bus.Valid1, bus.DivErr, bus.Busy, bus.DivStart, bus.DivAck,
         bus.DivXin, bus.DivYin, bus.Result_Q, bus.Result_R} !== 24'h000000) begin
      failures++;
      $display("FAIL midreset_clear: got %h expected 000000",
               {bus.Grant, bus.Valid0, bus.Valid1, bus.DivErr, bus.Busy, bus.DivStart, bus.DivAck,
                bus.DivXin, bus.DivYin, bus.Result_Q, bus.Result_R});
    end
    bus.Req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vseen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.Valid0 || bus.Valid1) vseen++;
    end
    checks++;
    if (vseen != 0) begin
      failures++;
      $display("FAIL midreset_no_valid: got %0d pulses expected 0", vseen);
    end
    bus.X0 = 4'd6; bus.Y0 = 4'd3; bus.Req0 = 1'b1;
    wait_valid(own, q, r, err, ack, ok);
    bus.Req0 = 1'b0;
    checks++;
    if ({ok, own, q, r, err} !== {1'b1, 2'b01, 4'd2, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_recover: got ok=%b own=%b q=%0d r=%0d err=%b expected ok=1 own=01 q=2 r=0 err=0",
               ok, own, q, r, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first_ack, second_start, nvalid;
    first_ack = -1; second_start = -1; nvalid = 0;
    bus.X0 = 4'd10; bus.Y0 = 4'd3; bus.Req0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.DivStart && first_ack >= 0 && second_start < 0) second_start = i;
      if (bus.DivAck && first_ack < 0) first_ack = i;
      if (bus.Valid0) begin
        nvalid++;
        checks++;
        if ({bus.Result_Q, bus.Result_R} !== {4'd3, 4'd1}) begin
          failures++;
          $display("FAIL b2b_result%0d: got q=%0d r=%0d expected q=3 r=1", nvalid, bus.Result_Q, bus.Result_R);
        end
        if (nvalid == 2) begin
          bus.Req0 = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (nvalid != 2) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d services expected 2", nvalid);
    end
    checks++;
    if (second_start < 0 || first_ack < 0 || (second_start - first_ack) < 2) begin
      failures++;
      $display("FAIL b2b_gap: got ack@%0d start@%0d expected gap >= 2", first_ack, second_start);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_div_zero();
    test_stability();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL exclusivity: got %0d violations expected 0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
